// File: rtl/lcm_pkg.sv
// Shared types and defaults for the LCM(1..n) prime-power sieve scheduler.
package lcm_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int NMAX_DEF  = 63;

  // One load cycle plus one shift-add step per multiplier bit.
  function automatic int mult_lat(input int w);
    return w + 1;
  endfunction

  localparam int MULT_LAT = mult_lat(WIDTH_DEF);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    POWER,
    MUL,
    MARK,
    FIN
  } state_t;

endpackage

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, one request at a time.
// LCM_SCHED_OVF_EN widens the product to 2*W bits and reports a nonzero upper half on hi_nz.
module seq_mult
  import lcm_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] p,
  output logic         hi_nz
);

`ifdef LCM_SCHED_OVF_EN
  localparam int PW = 2 * W;
`else
  localparam int PW = W;
`endif
  localparam int CW = $clog2(W + 2);

  logic [PW-1:0] mcand;
  logic [PW-1:0] prod;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (req && !run) begin
        mcand  <= PW'(a);
        mplier <= b;
        prod   <= '0;
        cnt    <= CW'(mult_lat(W) - 1);
        run    <= 1'b1;
      end else if (run) begin
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign p = prod[W-1:0];

`ifdef LCM_SCHED_OVF_EN
  assign hi_nz = |prod[PW-1:W];
`else
  assign hi_nz = 1'b0;
`endif

endmodule

// File: rtl/lcm_sched.sv
// LCM(1..n) scheduler: prime-power sieve over a composite bitmap, one shared multiplier.
// Build with LCM_SCHED_OVF_EN to detect products wider than WIDTH bits.
//
// state | meaning
// IDLE  | waiting for start, outputs held
// SCAN  | find next unmarked k (a prime), or finish when k > n
// POWER | raise p to the largest power not exceeding n
// MUL   | acc = acc * p^e on the shared multiplier
// MARK  | mark multiples of p as composite, one per cycle
// FIN   | publish result, pulse done, drop busy
module lcm_sched
  import lcm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NMAX  = NMAX_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [$clog2(NMAX+1)-1:0]   n,
  output logic                        busy,
  output logic                        done,
  output logic [WIDTH-1:0]            result,
  output logic                        overflow
);

  localparam int NW = $clog2(NMAX + 1);
  localparam int KW = NW + 1;
  localparam int MW = NW + 2;
  localparam logic [NW-1:0] NMAX_N = NW'(NMAX);

  state_t           state;
  logic [NW-1:0]    n_lat;
  logic [KW-1:0]    k;
  logic [NW-1:0]    p_q;
  logic [NW-1:0]    pw;
  logic [MW-1:0]    m;
  logic [WIDTH-1:0] acc;
  logic [NMAX:0]    bitmap;
  logic             mul_req;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic             mul_hi_nz;
  logic [2*NW-1:0]  pw_next;

  // Full-width product so the bound test never wraps.
  assign pw_next = (2*NW)'(pw) * (2*NW)'(p_q);

  seq_mult #(.W(WIDTH)) u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (mul_req),
    .a     (acc),
    .b     (WIDTH'(pw)),
    .done  (mul_done),
    .p     (mul_p),
    .hi_nz (mul_hi_nz)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      acc      <= WIDTH'(1);
      bitmap   <= '0;
      n_lat    <= '0;
      k        <= '0;
      p_q      <= '0;
      pw       <= '0;
      m        <= '0;
      mul_req  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_lat    <= (n > NMAX_N) ? NMAX_N : n;
            acc      <= WIDTH'(1);
            bitmap   <= '0;
            k        <= KW'(2);
            overflow <= 1'b0;
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (k > KW'(n_lat)) begin
            state <= FIN;
          end else if (bitmap[k[NW-1:0]]) begin
            k <= k + 1'b1;
          end else begin
            p_q   <= k[NW-1:0];
            pw    <= k[NW-1:0];
            state <= POWER;
          end
        end
        POWER: begin
          if (pw_next <= (2*NW)'(n_lat)) begin
            pw <= pw_next[NW-1:0];
          end else begin
            mul_req <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          mul_req <= 1'b0;
          if (mul_done) begin
            acc <= mul_p;
            if (mul_hi_nz) overflow <= 1'b1;
            m     <= MW'(p_q) << 1;
            state <= MARK;
          end
        end
        MARK: begin
          if (m <= MW'(n_lat)) begin
            bitmap[m[NW-1:0]] <= 1'b1;
            m <= m + MW'(p_q);
          end else begin
            k     <= KW'(p_q) + 1'b1;
            state <= SCAN;
          end
        end
        FIN: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcm_sched.sv
// Directed bench for lcm_sched; expectations follow LCM_SCHED_OVF_EN when it is defined.
module tb_lcm_sched;

`ifdef LCM_SCHED_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif
  localparam int BUDGET = 64 * (64 + 4) + 4 * 63;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  n;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  // Run observations, written by the tasks below.
  logic [63:0] r_res;
  logic        r_ovf;
  logic        r_busy_at_done;
  int          r_cyc;
  bit          r_busy_ok;
  bit          r_seen;
  int          r_extra;

  int pp63[18] = '{32, 27, 25, 49, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53, 59, 61};
  longint unsigned exp63;

  lcm_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .n        (n),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [5:0] nv);
    @(negedge clk);
    n     = nv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    r_cyc     = 1;
    r_busy_ok = 1'b1;
    r_seen    = 1'b0;
    while (r_cyc <= BUDGET + 8) begin
      if (done) begin
        r_seen = 1'b1;
        break;
      end
      if (!busy) r_busy_ok = 1'b0;
      @(negedge clk);
      r_cyc++;
    end
    r_res          = result;
    r_ovf          = overflow;
    r_busy_at_done = busy;
    r_extra        = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) r_extra++;
    end
  endtask

  task automatic run_lcm(input logic [5:0] nv);
    kick(nv);
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp63 = 64'd1;
    foreach (pp63[i]) exp63 = exp63 * longint'(pp63[i]);

    rst_n = 1'b0;
    start = 1'b0;
    n     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    run_lcm(6'd20);
    chk("n20_done", r_seen, 1);
    chk("n20_result", r_res, 64'd232792560);
    chk("n20_ovf", r_ovf, 0);
    chk("n20_busy_low_at_done", r_busy_at_done, 0);
    chk("n20_busy_held", r_busy_ok, 1);
    chk("n20_single_done", r_extra, 0);

    run_lcm(6'd10);
    chk("n10_result", r_res, 64'd2520);
    run_lcm(6'd1);
    chk("n1_done", r_seen, 1);
    chk("n1_result", r_res, 64'd1);
    run_lcm(6'd0);
    chk("n0_result", r_res, 64'd1);
    chk("n0_ovf", r_ovf, 0);

    run_lcm(6'd46);
    chk("n46_result", r_res, 64'd9419588158802421600);
    chk("n46_ovf", r_ovf, 0);

    run_lcm(6'd47);
    chk("n47_result", r_res, 64'd18445529768394128032);
    chk("n47_ovf", r_ovf, OVF_ON);

    // A second start while busy must not disturb the run in flight.
    kick(6'd20);
    repeat (10) @(negedge clk);
    n     = 6'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("busy_start_done", r_seen, 1);
    chk("busy_start_result", r_res, 64'd232792560);
    chk("busy_start_single", r_extra, 0);

    run_lcm(6'd63);
    chk("n63_done", r_seen, 1);
    chk("n63_result", r_res, exp63);
    chk("n63_ovf", r_ovf, OVF_ON);
    chk("n63_latency", r_cyc <= BUDGET, 1);
    chk("n63_busy_held", r_busy_ok, 1);

    // Abort during the first multiply (starts about 6 cycles after accept).
    kick(6'd20);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", overflow, 0);
    r_extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) r_extra++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) r_extra++;
    end
    chk("abort_no_done", r_extra, 0);

    run_lcm(6'd6);
    chk("after_abort_done", r_seen, 1);
    chk("after_abort_result", r_res, 64'd60);
    chk("after_abort_ovf", r_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lcm_sched.md
LCM_SCHED -- requirements
Module: lcm_sched

Interface
REQ-001 Parameter WIDTH, 64, accumulator/result width in bits.
REQ-002 Parameter NMAX, 63, largest accepted n; n port width is clog2(NMAX+1).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port start  input  1  one-cycle request to compute LCM(1..n).
REQ-006 Port n  input  clog2(NMAX+1)  upper bound of the range, sampled only when start is accepted.
REQ-007 Port busy  output  1  high while a computation is in progress.
REQ-008 Port done  output  1  one-cycle pulse when result is valid.
REQ-009 Port result  output  WIDTH  LCM(1..n) modulo 2^WIDTH; held until the next accepted start.
REQ-010 Port overflow  output  1  sticky per run; set if any product exceeded WIDTH bits.

Function
REQ-011 Method SHALL be a prime-power sieve: acc = product over primes p<=n of the largest p^e<=n.
REQ-012 FSM states SHALL be IDLE, SCAN, POWER, MUL, MARK, FIN.
REQ-013 IDLE: start accepted only when busy=0; start while busy SHALL be ignored with no effect on the running computation.
REQ-014 On accept: latch n, acc=1, clear composite bitmap[0..NMAX], k=2, overflow=0, busy=1, go to SCAN.
REQ-015 SCAN: if k>n go to FIN; if bitmap[k] set, k=k+1 and stay; else p=k, pw=p, go to POWER.
REQ-016 POWER: if pw*p<=n, pw=pw*p and stay, else go to MUL; comparison SHALL use full-width product (no wrap).
REQ-017 MUL: issue one request acc*pw to the shared multiplier, wait for its done, write low WIDTH bits to acc, go to MARK.
REQ-018 MARK: m=2p; while m<=n set bitmap[m], m=m+p, one bit per cycle; then k=p+1, go to SCAN.
REQ-019 FIN: result=acc, done=1 for exactly one cycle, busy=0 in the same cycle, go to IDLE.
REQ-020 n<2 SHALL yield result=1, overflow=0, done via SCAN->FIN.
REQ-021 n>NMAX SHALL be clamped to NMAX at latch time.
REQ-022 Total latency from accepted start to done SHALL be at most 64*(WIDTH+4)+4*NMAX cycles.
REQ-023 Multiplier SHALL be iterative shift-add, one bit per cycle, WIDTH+1 cycles per operation, one request outstanding.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, busy=0, done=0, result=0, overflow=0, acc=1, bitmap cleared, multiplier idle.
REQ-025 Reset mid-computation SHALL abort it with no done pulse; first start after release behaves as from power-up.

Configuration
REQ-026 Macro LCM_SCHED_OVF_EN defined: multiplier computes 2*WIDTH-bit product; nonzero upper half sets overflow (sticky until next accept).
REQ-027 Macro LCM_SCHED_OVF_EN undefined: only low WIDTH bits computed, overflow tied to 0, result is the truncated product.

Structure
REQ-028 Shared package lcm_pkg SHALL hold the FSM state enum, WIDTH/NMAX defaults and the multiplier latency constant.
REQ-029 Sub-module seq_mult SHALL implement the iterative multiplier (ports: clk, rst_n, req, a, b, done, p, hi_nz).
REQ-030 Bitmap SHALL be a flop vector of NMAX+1 bits; no memory macro.

Verification
REQ-031 n=20, start -> done once, result=232792560, overflow=0.
REQ-032 n=10, then n=1, then n=0 back-to-back after each done -> results 2520, 1, 1.
REQ-033 n=46 -> result=9419588158802421600, overflow=0; n=47 with LCM_SCHED_OVF_EN -> overflow=1.
REQ-034 n=20 started, start pulsed with n=5 while busy -> single done, result=232792560.
REQ-035 n=20 started, rst_n low in MUL state -> outputs zero immediately, no done; new n=6 start -> result=60.
REQ-036 n=NMAX -> done within bound of REQ-022; busy high every cycle from accept to done.
